// File: rtl/multi_mode_game_counter_v2.sv
// ---------------------------------------------------------------------------
// multi_mode_game_counter_v2
//
// Purpose:
//   Up/down counter game with a run-time step. Arriving at MAX through
//   counting is a "winner" event and arriving at 0 is a "loser" event. Each
//   event type has its own tally. When either tally reaches TMAX the block
//   spends one OVER cycle with gameover/who asserted and the final count and
//   tallies still visible. It then restarts at 0 (counting up) or MAX
//   (counting down).
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   en           in   advance count by step
//   dir          in   0 = up, 1 = down
//   step         in   step size, 0 = hold
//   init         in   load init_value (takes priority over en)
//   init_value   in   value to load
//   count        out  registered count
//   winner       out  count == MAX
//   loser        out  count == 0
//   winner_tally out  entries into MAX this game
//   loser_tally  out  entries into 0 this game
//   gameover     out  one-cycle game-finished pulse (registered)
//   who          out  2'b10 winner filled, 2'b01 loser filled, else 2'b00
//
// STEP_WIDTH is assumed to be no larger than WIDTH.
// ---------------------------------------------------------------------------
module multi_mode_game_counter_v2 #(
    parameter int WIDTH       = 4,
    parameter int TALLY_WIDTH = 2,
    parameter int STEP_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   dir,
    input  logic [STEP_WIDTH-1:0]  step,
    input  logic                   init,
    input  logic [WIDTH-1:0]       init_value,
    output logic [WIDTH-1:0]       count,
    output logic                   winner,
    output logic                   loser,
    output logic [TALLY_WIDTH-1:0] winner_tally,
    output logic [TALLY_WIDTH-1:0] loser_tally,
    output logic                   gameover,
    output logic [1:0]             who
);

    typedef enum logic {RUN, OVER} state_t;

    localparam logic [WIDTH-1:0]       MAX     = '1;
    localparam logic [WIDTH:0]         MAX_EXT = {1'b0, MAX};
    // Tally value one below TMAX: the increment from here ends the game.
    localparam logic [TALLY_WIDTH-1:0] TLAST   = TALLY_WIDTH'((1 << TALLY_WIDTH) - 2);
    localparam logic [1:0]             WHO_WIN  = 2'b10;
    localparam logic [1:0]             WHO_LOSE = 2'b01;

    state_t           state;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_next;
    logic             hit_max;
    logic             hit_zero;

    // Arithmetic is done one bit wider so that overflow is caught by the
    // clamp compare and does not wrap silently.
    assign count_ext = {1'b0, count};
    assign step_ext  = (WIDTH+1)'(step);
    assign sum       = count_ext + step_ext;
    assign diff      = count_ext - step_ext;

    always_comb begin
        step_next = count;
        if (step_ext != '0) begin
            if (!dir) begin
                if (count == MAX)          step_next = '0;
                else if (sum > MAX_EXT)    step_next = MAX;
                else                       step_next = sum[WIDTH-1:0];
            end else begin
                if (count == '0)           step_next = MAX;
                else if (count_ext < step_ext) step_next = '0;
                else                       step_next = diff[WIDTH-1:0];
            end
        end
    end

    // An event is only counted when the value actually changes into a
    // boundary, so holding at a boundary never re-counts.
    assign hit_max  = (step_next == MAX) && (count != MAX);
    assign hit_zero = (step_next == '0)  && (count != '0);

    assign winner = (count == MAX);
    assign loser  = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            count        <= '0;
            winner_tally <= '0;
            loser_tally  <= '0;
            gameover     <= 1'b0;
            who          <= 2'b00;
        end else begin
            case (state)
                RUN: begin
                    gameover <= 1'b0;
                    who      <= 2'b00;
                    if (init) begin
                        // Loads never touch the tallies.
                        count <= init_value;
                    end else if (en) begin
                        count <= step_next;
                        if (hit_max) begin
                            winner_tally <= winner_tally + 1'b1;
                            if (winner_tally == TLAST) begin
                                state    <= OVER;
                                gameover <= 1'b1;
                                who      <= WHO_WIN;
                            end
                        end
                        if (hit_zero) begin
                            loser_tally <= loser_tally + 1'b1;
                            if (loser_tally == TLAST) begin
                                state    <= OVER;
                                gameover <= 1'b1;
                                who      <= WHO_LOSE;
                            end
                        end
                    end
                end
                OVER: begin
                    // en/init ignored; restart value depends on direction
                    // and is not a tally event.
                    state        <= RUN;
                    gameover     <= 1'b0;
                    who          <= 2'b00;
                    winner_tally <= '0;
                    loser_tally  <= '0;
                    count        <= dir ? MAX : '0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
